// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetching over a
// req/ack instruction-memory handshake with stall, hold and branch-flush control.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PCWrite_i,
  input  logic        Stall_i,
  input  logic        MemStall_i,
  input  logic        Flush_i,
  input  logic [31:0] BranchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // REQ: fetch of pc_q outstanding; HOLD: fetched word parked in buf_q;
  // DROP: wrong-path fetch still outstanding, redirect waits in target_q.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] pc_out_d, instr_d;
  logic            valid_d;
  logic            hold, flush;

  // Any stall source freezes the stage; a branch flush only acts when not held.
  assign hold  = Stall_i | ~PCWrite_i | MemStall_i;
  assign flush = Flush_i & ~hold;

  // Memory sees the current PC; no request while parked or in reset.
  assign imem_addr_o = pc_q;
  assign imem_req_o  = ~rst_i & (state_q != S_HOLD);

  // State register, PC, buffers and IF/ID register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      target_q <= '0;
      pc_o     <= '0;
      instr_o  <= NOP_INSTR;
      valid_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      target_q <= target_d;
      pc_o     <= pc_out_d;
      instr_o  <= instr_d;
      valid_o  <= valid_d;
    end
  end

  // Next-state and next IF/ID contents.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    target_d = target_q;
    pc_out_d = pc_o;
    instr_d  = instr_o;
    valid_d  = valid_o;

    case (state_q)
      S_REQ: begin
        if (imem_ack_i) begin
          if (flush) begin
            pc_d     = BranchTarget_i;
            pc_out_d = '0;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
          end else if (!hold) begin
            pc_out_d = pc_q;
            instr_d  = imem_data_i;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
          end else begin
            buf_d   = imem_data_i;
            state_d = S_HOLD;
          end
        end else begin
          if (flush) begin
            target_d = BranchTarget_i;
            pc_out_d = '0;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
            state_d  = S_DROP;
          end else if (!hold) begin
            pc_out_d = '0;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (flush) begin
          pc_d     = BranchTarget_i;
          pc_out_d = '0;
          instr_d  = NOP_INSTR;
          valid_d  = 1'b0;
          state_d  = S_REQ;
        end else if (!hold) begin
          pc_out_d = pc_q;
          instr_d  = buf_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_STEP;
          state_d  = S_REQ;
        end
      end

      S_DROP: begin
        // IF/ID already holds a bubble here, so Flush_i cannot be genuine.
        if (!hold) begin
          pc_out_d = '0;
          instr_d  = NOP_INSTR;
          valid_d  = 1'b0;
        end
        if (imem_ack_i) begin
          pc_d    = target_q;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/flush/latency
// traffic, all checked every cycle against a transaction-level model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        PCWrite_i;
  logic        Stall_i;
  logic        MemStall_i;
  logic        Flush_i;
  logic [31:0] BranchTarget_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .PCWrite_i     (PCWrite_i),
    .Stall_i       (Stall_i),
    .MemStall_i    (MemStall_i),
    .Flush_i       (Flush_i),
    .BranchTarget_i(BranchTarget_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: next fetch address, an optional parked word, an optional pending
  // redirect behind a wrong-path fetch, and the expected IF/ID contents.
  logic [31:0] m_pc;
  bit          m_have_buf;
  logic [31:0] m_buf;
  bit          m_draining;
  logic [31:0] m_target;
  logic [31:0] m_pc_o;
  logic [31:0] m_instr;
  logic        m_valid;

  // Memory environment: acks after mem_lat waiting cycles, returns addr>>2.
  int mem_cnt;
  int mem_lat;
  bit rand_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_pc_o  = 32'h0;
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_have_buf = 0;
    m_buf      = 32'h0;
    m_draining = 0;
    m_target   = 32'h0;
    model_bubble();
  endtask

  // One clock cycle: check IF/ID, drive inputs, answer memory, advance model.
  // fa: 0 = memory decides ack, 1 = force ack high.
  task automatic step(input logic r, input logic st, input logic pcw, input logic ms,
                      input logic fl, input logic [31:0] bt, input int fa);
    logic        a;
    logic        hold;
    logic        flush;
    logic [31:0] d;
    logic [31:0] word;
    logic        req_seen;

    chk("pc_o", pc_o, m_pc_o);
    chk("instr_o", instr_o, m_instr);
    chk("valid_o", 32'(valid_o), 32'(m_valid));

    rst_i          = r;
    Stall_i        = st;
    PCWrite_i      = pcw;
    MemStall_i     = ms;
    Flush_i        = fl;
    BranchTarget_i = bt;
    #1;
    chk("imem_req_o", 32'(imem_req_o), 32'(!r && !m_have_buf));
    chk("imem_addr_o", imem_addr_o, m_pc);

    req_seen = imem_req_o;
    if (fa == 1) a = 1'b1;
    else         a = req_seen && (mem_cnt >= mem_lat);
    d = imem_addr_o >> 2;
    imem_ack_i  = a;
    imem_data_i = d;

    hold  = st || !pcw || ms;
    flush = fl && !hold;

    if (r) begin
      model_reset();
    end else if (m_draining) begin
      if (!hold) model_bubble();
      if (a) begin
        m_pc       = m_target;
        m_draining = 0;
      end
    end else if (m_have_buf || a) begin
      word = m_have_buf ? m_buf : d;
      if (flush) begin
        m_pc       = bt;
        m_have_buf = 0;
        model_bubble();
      end else if (!hold) begin
        m_pc_o     = m_pc;
        m_instr    = word;
        m_valid    = 1'b1;
        m_pc       = m_pc + 32'd4;
        m_have_buf = 0;
      end else begin
        m_buf      = word;
        m_have_buf = 1;
      end
    end else begin
      if (flush) begin
        m_target   = bt;
        m_draining = 1;
        model_bubble();
      end else if (!hold) begin
        model_bubble();
      end
    end

    if (req_seen && a) begin
      mem_cnt = 0;
      if (rand_lat) mem_lat = $urandom_range(0, 3);
    end else if (req_seen) begin
      mem_cnt++;
    end else begin
      mem_cnt = 0;
    end

    @(negedge clk);
  endtask

  task automatic nrm();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
  endtask

  initial begin
    logic        r, st, pcw, ms, fl;
    logic [31:0] bt;

    vectors        = 0;
    miscompares    = 0;
    mem_cnt        = 0;
    mem_lat        = 0;
    rand_lat       = 0;
    rst_i          = 1'b1;
    Stall_i        = 1'b0;
    PCWrite_i      = 1'b1;
    MemStall_i     = 1'b0;
    Flush_i        = 1'b0;
    BranchTarget_i = 32'h0;
    imem_ack_i     = 1'b0;
    imem_data_i    = 32'h0;
    @(negedge clk);
    model_reset();

    // Zero-wait streaming after reset.
    do_reset();
    nrm();
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_o, 32'(i * 4));
      chk("seq_instr", instr_o, 32'(i));
      chk("seq_valid", 32'(valid_o), 32'd1);
      nrm();
    end

    // One-cycle load-use stall while pc 8 is acked.
    do_reset();
    nrm();
    nrm();
    chk("stall_pre_pc", pc_o, 32'h4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    chk("stall_hold_pc", pc_o, 32'h4);
    chk("stall_no_req", 32'(imem_req_o), 32'd0);
    nrm();
    chk("stall_post_pc", pc_o, 32'h8);
    chk("stall_post_instr", instr_o, 32'h2);
    nrm();
    chk("stall_next_pc", pc_o, 32'hC);

    // Flush with ack at pc 0x10.
    do_reset();
    repeat (4) nrm();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_instr", instr_o, NOP);
    chk("flush_addr", imem_addr_o, 32'h100);
    nrm();
    chk("flush_tgt_pc", pc_o, 32'h100);
    chk("flush_tgt_instr", instr_o, 32'h40);

    // Flush one cycle into a 3-cycle fetch of 0x20.
    do_reset();
    repeat (8) nrm();
    mem_lat = 2;
    chk("drop_addr0", imem_addr_o, 32'h20);
    nrm();
    chk("drop_addr1", imem_addr_o, 32'h20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 0);
    chk("drop_addr2", imem_addr_o, 32'h20);
    chk("drop_req2", 32'(imem_req_o), 32'd1);
    chk("drop_valid2", 32'(valid_o), 32'd0);
    nrm();
    chk("drop_addr3", imem_addr_o, 32'h100);
    chk("drop_valid3", 32'(valid_o), 32'd0);
    mem_lat = 0;
    nrm();
    chk("drop_tgt_pc", pc_o, 32'h100);

    // MemStall for 5 cycles with a concurrent flush.
    do_reset();
    nrm();
    nrm();
    repeat (5) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 0);
      chk("ms_pc", pc_o, 32'h4);
      chk("ms_addr", imem_addr_o, 32'h8);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 0);
    chk("ms_rel_valid", 32'(valid_o), 32'd0);
    chk("ms_rel_addr", imem_addr_o, 32'h200);
    nrm();
    chk("ms_tgt_pc", pc_o, 32'h200);
    chk("ms_tgt_instr", instr_o, 32'h80);

    // Reset while draining a wrong-path fetch, with an ack in the reset cycle.
    do_reset();
    mem_lat = 3;
    nrm();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1);
    chk("rst_drop_addr", imem_addr_o, 32'h0);
    chk("rst_drop_valid", 32'(valid_o), 32'd0);
    mem_lat = 0;
    nrm();
    chk("rst_drop_pc", pc_o, 32'h0);
    chk("rst_drop_next", imem_addr_o, 32'h4);

    // PC wrap past the top of the address space.
    do_reset();
    nrm();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 0);
    nrm();
    nrm();
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr_o, 32'h0);
    nrm();
    chk("wrap_zero_pc", pc_o, 32'h0);

    // Random traffic with variable memory latency.
    rand_lat = 1;
    do_reset();
    repeat (3000) begin
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 9) == 0);
      pcw = ($urandom_range(0, 9) != 0);
      ms  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      bt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom();
      step(r, st, pcw, ms, fl, bt, 0);
    end
    chk("final_pc", pc_o, m_pc_o);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
